instr_pipe_regs: RTL and testbench

- Four-stage instruction pipeline register chain: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Produces the per-stage instruction words iiO, ieO, emO and mwO, plus matching PCs, for the hazard/forwarding control unit and the datapath.
- Consumes that unit's stall/flush selects to hold stages or inject bubbles.
- Keeps a retired-instruction counter for debug and performance checks.

---
 rtl/instr_pipe_regs_if.sv | 28 ++
 rtl/instr_pipe_regs.sv | 76 +++++++
 tb/tb_instr_pipe_regs.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/instr_pipe_regs_if.sv
// instr_pipe_regs_if: bundles the fetch inputs, stall/flush selects and the
// per-stage instruction/PC/valid outputs of the pipeline register chain.
//   master: control unit / datapath side; drives instr_in, pc_in, freeze, if_ctl, ex_ctl
//   slave : pipeline register side; drives iiO, ieO, emO, mwO, pc_ii/ie/em, valid_*, retired
interface instr_pipe_regs_if #(
    parameter int IW  = 32,
    parameter int PCW = 32
);
    logic [IW-1:0]  instr_in;
    logic [PCW-1:0] pc_in;
    logic           freeze;
    logic [1:0]     if_ctl;
    logic [1:0]     ex_ctl;
    logic [IW-1:0]  iiO, ieO, emO, mwO;
    logic [PCW-1:0] pc_ii, pc_ie, pc_em;
    logic           valid_ie, valid_em, valid_mw;
    logic [31:0]    retired;

    modport master (
        output instr_in, pc_in, freeze, if_ctl, ex_ctl,
        input  iiO, ieO, emO, mwO, pc_ii, pc_ie, pc_em, valid_ie, valid_em, valid_mw, retired
    );

    modport slave (
        input  instr_in, pc_in, freeze, if_ctl, ex_ctl,
        output iiO, ieO, emO, mwO, pc_ii, pc_ie, pc_em, valid_ie, valid_em, valid_mw, retired
    );
endinterface

// File: rtl/instr_pipe_regs.sv
// instr_pipe_regs: IF/ID, ID/EX, EX/MEM, MEM/WB instruction/PC registers with
// hold/flush/bubble control and a retired-instruction counter.
//   clk, rst : clock and synchronous active-high reset
//   bus      : instr_pipe_regs_if.slave (fetch inputs, freeze, if_ctl, ex_ctl in;
//              stage words, PCs, valid flags, retired out)
module instr_pipe_regs #(
    parameter int             IW     = 32,
    parameter int             PCW    = 32,
    parameter logic [IW-1:0]  BUBBLE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    instr_pipe_regs_if.slave  bus
);
    localparam logic [5:0] BOP = BUBBLE[IW-1:IW-6];

    logic [IW-1:0]  ii_q, ii_d, ie_q, ie_d, em_q, em_d, mw_q, mw_d;
    logic [PCW-1:0] pii_q, pii_d, pie_q, pie_d, pem_q, pem_d;
    logic           vie_q, vie_d, vem_q, vem_d, vmw_q, vmw_d;
    logic [31:0]    ret_q, ret_d;

    always_comb begin
        ii_d  = bus.freeze ? ii_q : bus.if_ctl == 2'd0 ? bus.instr_in : bus.if_ctl == 2'd1 ? ii_q : BUBBLE;
        pii_d = (bus.freeze || bus.if_ctl == 2'd1) ? pii_q : bus.pc_in;
        ie_d  = bus.freeze ? ie_q : bus.ex_ctl == 2'd0 ? ii_q : BUBBLE;
        pie_d = bus.freeze ? pie_q : pii_q;
        em_d  = bus.freeze ? em_q : ie_q;
        pem_d = bus.freeze ? pem_q : pie_q;
        mw_d  = bus.freeze ? mw_q : em_q;
        // valid flags follow the word they are registered with, so a frozen stage keeps its flag
        vie_d = ie_d[IW-1:IW-6] != BOP;
        vem_d = em_d[IW-1:IW-6] != BOP;
        vmw_d = mw_d[IW-1:IW-6] != BOP;
        ret_d = ret_q + 32'(!bus.freeze && em_q[IW-1:IW-6] != BOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ii_q  <= BUBBLE;
            ie_q  <= BUBBLE;
            em_q  <= BUBBLE;
            mw_q  <= BUBBLE;
            pii_q <= '0;
            pie_q <= '0;
            pem_q <= '0;
            vie_q <= 1'b0;
            vem_q <= 1'b0;
            vmw_q <= 1'b0;
            ret_q <= '0;
        end else begin
            ii_q  <= ii_d;
            ie_q  <= ie_d;
            em_q  <= em_d;
            mw_q  <= mw_d;
            pii_q <= pii_d;
            pie_q <= pie_d;
            pem_q <= pem_d;
            vie_q <= vie_d;
            vem_q <= vem_d;
            vmw_q <= vmw_d;
            ret_q <= ret_d;
        end
    end

    assign bus.iiO      = ii_q;
    assign bus.ieO      = ie_q;
    assign bus.emO      = em_q;
    assign bus.mwO      = mw_q;
    assign bus.pc_ii    = pii_q;
    assign bus.pc_ie    = pie_q;
    assign bus.pc_em    = pem_q;
    assign bus.valid_ie = vie_q;
    assign bus.valid_em = vem_q;
    assign bus.valid_mw = vmw_q;
    assign bus.retired  = ret_q;
endmodule

// File: tb/tb_instr_pipe_regs.sv
// tb_instr_pipe_regs: random and directed stimulus checked against a stage-array model.
module tb_instr_pipe_regs;
    localparam logic [31:0] BUB = 32'h8000_0000;
    localparam logic [31:0] IA = 32'h0400_0001, IB = 32'h0800_0002, IC = 32'h0C00_0003, ID = 32'h1000_0004;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_pipe_regs_if #(.IW(32), .PCW(32)) pif ();
    instr_pipe_regs #(.IW(32), .PCW(32), .BUBBLE(BUB)) dut (.clk(clk), .rst(rst), .bus(pif));

    logic [31:0] m_w[4];
    logic [31:0] m_p[3];
    logic [31:0] m_ret;
    bit          mvalid = 1'b0;
    int          n_chk = 0, n_err = 0;

    function automatic logic bub(input logic [31:0] w);
        return w[31:26] == 6'd32;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic fr, input logic [1:0] ic, input logic [1:0] ec,
                        input logic [31:0] ins, input logic [31:0] pc);
        logic [31:0] nw[4];
        logic [31:0] np[3];
        logic [31:0] nret;
        rst = r; pif.freeze = fr; pif.if_ctl = ic; pif.ex_ctl = ec; pif.instr_in = ins; pif.pc_in = pc;
        nw = m_w; np = m_p; nret = m_ret;
        if (r) begin
            nw = '{BUB, BUB, BUB, BUB};
            np = '{0, 0, 0};
            nret = 0;
        end else if (!fr) begin
            if (!bub(m_w[2])) nret = m_ret + 1;
            nw[3] = m_w[2];
            nw[2] = m_w[1];  np[2] = m_p[1];
            nw[1] = (ec == 2'd0) ? m_w[0] : BUB;  np[1] = m_p[0];
            nw[0] = (ic == 2'd0) ? ins : (ic == 2'd1) ? m_w[0] : BUB;
            np[0] = (ic == 2'd1) ? m_p[0] : pc;
        end
        @(posedge clk);
        #1;
        m_w = nw; m_p = np; m_ret = nret;
        if (r) mvalid = 1'b1;
    endtask

    task automatic go(input logic [31:0] ins, input logic [31:0] pc);
        tick(1'b0, 1'b0, 2'd0, 2'd0, ins, pc);
    endtask

    always @(negedge clk) if (mvalid) begin
        chk("iiO", pif.iiO, m_w[0]);
        chk("ieO", pif.ieO, m_w[1]);
        chk("emO", pif.emO, m_w[2]);
        chk("mwO", pif.mwO, m_w[3]);
        chk("pc_ii", pif.pc_ii, m_p[0]);
        chk("pc_ie", pif.pc_ie, m_p[1]);
        chk("pc_em", pif.pc_em, m_p[2]);
        chk("valid_ie", 32'(pif.valid_ie), 32'(!bub(m_w[1])));
        chk("valid_em", 32'(pif.valid_em), 32'(!bub(m_w[2])));
        chk("valid_mw", 32'(pif.valid_mw), 32'(!bub(m_w[3])));
        chk("retired", pif.retired, m_ret);
    end

    initial begin
        logic [31:0] ins;
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        chk("rst_iiO", pif.iiO, BUB);
        chk("rst_mwO", pif.mwO, BUB);
        chk("rst_pc_em", pif.pc_em, 32'h0);
        chk("rst_valid_mw", 32'(pif.valid_mw), 32'h0);
        chk("rst_retired", pif.retired, 32'h0);

        // single instruction latency
        go(32'h0400_0821, 32'd4);
        chk("lat_iiO", pif.iiO, 32'h0400_0821);
        go(BUB, 32'd8);
        chk("lat_ieO", pif.ieO, 32'h0400_0821);
        go(BUB, 32'd12);
        chk("lat_emO", pif.emO, 32'h0400_0821);
        chk("lat_pc_em", pif.pc_em, 32'd4);
        go(BUB, 32'd16);
        chk("lat_mwO", pif.mwO, 32'h0400_0821);
        chk("lat_retired", pif.retired, 32'd1);

        // load-use stall
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        go(IA, 32'h100); go(IB, 32'h104); go(IC, 32'h108);
        tick(1'b0, 1'b0, 2'd1, 2'd1, ID, 32'h10C);
        chk("stall_iiO", pif.iiO, IC);
        chk("stall_ieO", pif.ieO, BUB);
        chk("stall_valid_ie", 32'(pif.valid_ie), 32'h0);
        go(BUB, 32'h10C);
        chk("stall_resume_ieO", pif.ieO, IC);
        go(BUB, 32'h110); go(BUB, 32'h114);
        chk("stall_retired", pif.retired, 32'd3);

        // taken branch flush
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        go(IA, 32'h200); go(IB, 32'h204); go(IC, 32'h208);
        tick(1'b0, 1'b0, 2'd2, 2'd2, ID, 32'h20C);
        chk("br_iiO", pif.iiO, BUB);
        chk("br_ieO", pif.ieO, BUB);
        chk("br_emO", pif.emO, IB);
        chk("br_pc_ii", pif.pc_ii, 32'h20C);
        chk("br_valid_em", 32'(pif.valid_em), 32'h1);
        go(BUB, 32'h300); go(BUB, 32'h304);
        chk("br_retired", pif.retired, 32'd2);

        // freeze overrides flush
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        go(IA, 32'h400); go(IB, 32'h404); go(IC, 32'h408); go(ID, 32'h40C);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 2'd2, 2'd2, IA, 32'h500);
        chk("frz_iiO", pif.iiO, ID);
        chk("frz_ieO", pif.ieO, IC);
        chk("frz_emO", pif.emO, IB);
        chk("frz_mwO", pif.mwO, IA);
        chk("frz_pc_ii", pif.pc_ii, 32'h40C);
        chk("frz_retired", pif.retired, 32'd1);

        // reset mid-stream while holding
        tick(1'b1, 1'b0, 2'd1, 2'd1, IA, 32'h600);
        chk("mrst_iiO", pif.iiO, BUB);
        chk("mrst_emO", pif.emO, BUB);
        chk("mrst_pc_ie", pif.pc_ie, 32'h0);
        chk("mrst_retired", pif.retired, 32'h0);

        // load with stall-bubble: old iiO is lost
        go(IA, 32'h700); go(IB, 32'h704);
        tick(1'b0, 1'b0, 2'd0, 2'd1, IC, 32'h708);
        chk("ld_bub_iiO", pif.iiO, IC);
        chk("ld_bub_ieO", pif.ieO, BUB);
        chk("ld_bub_emO", pif.emO, IA);

        // retired wrap via backdoor preload
        tick(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
        go(IA, 32'h800); go(BUB, 32'h804); go(BUB, 32'h808);
        dut.ret_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        go(BUB, 32'h80C);
        chk("wrap_retired", pif.retired, 32'h0);
        chk("wrap_mwO", pif.mwO, IA);

        // random
        for (int i = 0; i < 500; i++) begin
            ins = $urandom();
            if ($urandom_range(3) == 0) ins[31:26] = 6'd32;
            tick($urandom_range(49) == 0, $urandom_range(4) == 0, 2'($urandom_range(3)),
                 2'($urandom_range(3)), ins, $urandom());
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
